// File: rtl/combine_driver_pkg.sv
// Shared types and constants for the combine-unit requester: FSM states and
// the byte layout of a job (header, then operands a..d).
package combine_driver_pkg;

    typedef enum logic [2:0] {
        LOAD,
        CLEAR,
        START,
        WAIT,
        HOLD
    } state_t;

    localparam int JOB_BYTES = 5;
    localparam int MODE_BIT  = 0;

    typedef logic [2:0] idx_t;

    localparam idx_t IDX_HDR = idx_t'(0);
    localparam idx_t IDX_A   = idx_t'(1);
    localparam idx_t IDX_B   = idx_t'(2);
    localparam idx_t IDX_C   = idx_t'(3);
    localparam idx_t IDX_D   = idx_t'(JOB_BYTES - 1);

endpackage

// File: rtl/combine_driver_if.sv
// Bundle of the job byte stream, compute-unit control/operand bus and the
// result valid/ready channel. master = driver side, slave = environment side.
interface combine_driver_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;

    logic             unit_reset;
    logic             unit_start;
    logic             unit_mode;
    logic [WIDTH-1:0] unit_a;
    logic [WIDTH-1:0] unit_b;
    logic [WIDTH-1:0] unit_c;
    logic [WIDTH-1:0] unit_d;
    logic             unit_done;
    logic [WIDTH-1:0] unit_result;

    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_error;
    logic             out_ready;

    logic             busy;

    modport master (
        input  in_valid, in_data,
        output in_ready,
        output unit_reset, unit_start, unit_mode, unit_a, unit_b, unit_c, unit_d,
        input  unit_done, unit_result,
        output out_valid, out_data, out_error,
        input  out_ready,
        output busy
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready,
        input  unit_reset, unit_start, unit_mode, unit_a, unit_b, unit_c, unit_d,
        output unit_done, unit_result,
        input  out_valid, out_data, out_error,
        output out_ready,
        input  busy
    );

endinterface

// File: rtl/combine_driver_job_loader.sv
// Collects one job from the byte stream into the mode/operand registers and
// pulses job_complete in the cycle the final byte is accepted.
module combine_driver_job_loader
    import combine_driver_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             job_complete,
    output logic             mode,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d
);

    idx_t cnt;
    logic take;

    assign take         = load_en && in_valid;
    assign job_complete = take && (cnt == IDX_D);

    // NOTE: state is written with <= so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: operands are reset explicitly so an aborted job leaves zeros on the unit.
            cnt  <= IDX_HDR;
            mode <= 1'b0;
            a    <= '0;
            b    <= '0;
            c    <= '0;
            d    <= '0;
        end else if (take) begin
            cnt <= job_complete ? IDX_HDR : idx_t'(cnt + 3'd1);
            case (cnt)
                IDX_HDR: mode <= in_data[MODE_BIT];
                IDX_A:   a    <= in_data;
                IDX_B:   b    <= in_data;
                IDX_C:   c    <= in_data;
                IDX_D:   d    <= in_data;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/combine_driver.sv
// Requester-side sequencer for the combine unit: load job, clear, start,
// wait for done (with timeout), then hold the result until consumed.
module combine_driver
    import combine_driver_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic             clock,
    input  logic             reset,
    combine_driver_if.master bus
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    typedef logic [CW-1:0] wcnt_t;
    localparam wcnt_t WAIT_LAST = wcnt_t'(TIMEOUT - 1);

    state_t           state, state_nx;
    wcnt_t            wait_cnt, wait_cnt_nx;
    logic [WIDTH-1:0] res_q, res_nx;
    logic             err_q, err_nx;
    logic             loading;
    logic             job_complete;
    logic             mode;
    logic [WIDTH-1:0] op_a, op_b, op_c, op_d;

    assign loading = (state == LOAD);

    combine_driver_job_loader #(.WIDTH(WIDTH)) u_job_loader (
        .clock        (clock),
        .reset        (reset),
        .load_en      (loading),
        .in_valid     (bus.in_valid),
        .in_data      (bus.in_data),
        .job_complete (job_complete),
        .mode         (mode),
        .a            (op_a),
        .b            (op_b),
        .c            (op_c),
        .d            (op_d)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= LOAD;
            wait_cnt <= '0;
            res_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
            res_q    <= res_nx;
            err_q    <= err_nx;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        res_nx      = res_q;
        err_nx      = err_q;
        case (state)
            LOAD:  if (job_complete) state_nx = CLEAR;
            CLEAR: state_nx = START;
            START: begin
                state_nx    = WAIT;
                wait_cnt_nx = '0;
            end
            WAIT: begin
                // Only the first done cycle is captured; the unit keeps updating afterwards.
                if (bus.unit_done) begin
                    res_nx   = bus.unit_result;
                    err_nx   = 1'b0;
                    state_nx = HOLD;
                end else if (wait_cnt == WAIT_LAST) begin
                    res_nx   = '0;
                    err_nx   = 1'b1;
                    state_nx = HOLD;
                end else begin
                    wait_cnt_nx = wcnt_t'(wait_cnt + 1'b1);
                end
            end
            HOLD:    if (bus.out_ready) state_nx = LOAD;
            default: state_nx = LOAD;
        endcase
    end

    // Handshake outputs decode registered state only; reset also holds the unit clear.
    assign bus.in_ready   = loading;
    assign bus.unit_reset = (state == CLEAR) || reset;
    assign bus.unit_start = (state == START);
    assign bus.out_valid  = (state == HOLD);
    assign bus.busy       = !loading;

    assign bus.unit_mode = mode;
    assign bus.unit_a    = op_a;
    assign bus.unit_b    = op_b;
    assign bus.unit_c    = op_c;
    assign bus.unit_d    = op_d;
    assign bus.out_data  = res_q;
    assign bus.out_error = err_q;

endmodule
